bcd_to_bin_serial: RTL and testbench

BCD_TO_BIN_SERIAL -- requirements
Module: bcd_to_bin_serial

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 10 +
 rtl/bcd_to_bin_serial.sv | 110 +++++++++++
 tb/tb_bcd_to_bin_serial.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial BCD-to-binary converter.
package bcd_pkg;

   // Converter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Number of shift steps needed to move two BCD digits into 7 binary bits
   localparam int unsigned SHIFT_CNT = 7;

   // Counter width, wide enough to hold 0 .. SHIFT_CNT-1
   localparam int unsigned CNT_W = 3;

   // Largest legal value of a single BCD digit
   localparam logic [3:0] BCD_MAX = 4'd9;

   // Working register: {tens, units, 7 result bits}
   localparam int unsigned WORK_W = 15;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction: a BCD field that reads 8 or more after
// a right shift had a tens/units carry folded into it and must lose 3.
module bcd_digit_adjust (
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Two-digit BCD (00-99) to 7-bit binary converter, one bit per clock using
// reverse double-dabble. Invalid digits short-circuit straight to completion
// with err set and a zero result.
module bcd_to_bin_serial
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] bcd_in,
   output logic       busy,
   output logic       done,
   output logic [6:0] bin_out,
   output logic       err
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_CNT - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [WORK_W-1:0]   r_work;
   logic                r_busy;
   logic                r_done;
   logic [6:0]          r_bin;
   logic                r_err;

   logic [WORK_W-1:0]   w_shift;
   logic [3:0]          w_tens_adj;
   logic [3:0]          w_units_adj;
   logic [WORK_W-1:0]   w_next;
   logic                w_bad_digit;

   // Input validity is a plain compare on the live bus; it only matters on the
   // accepting edge, so nothing is registered here.
   assign w_bad_digit = (bcd_in[7:4] > BCD_MAX) || (bcd_in[3:0] > BCD_MAX);

   // Shift first, then correct each digit field.
   assign w_shift = r_work >> 1;

   bcd_digit_adjust u_adj_tens (
      .i_digit (w_shift[14:11]),
      .o_digit (w_tens_adj)
   );

   bcd_digit_adjust u_adj_units (
      .i_digit (w_shift[10:7]),
      .o_digit (w_units_adj)
   );

   assign w_next = {w_tens_adj, w_units_adj, w_shift[6:0]};

   // Control FSM with registered status outputs; bin_out/err only change on
   // completion so no partial result is ever visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_work  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_bin   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_busy <= 1'b1;
                  if (w_bad_digit) begin
                     r_bin   <= '0;
                     r_err   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_work  <= {bcd_in, 7'b0};
                     r_cnt   <= '0;
                     r_state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               r_work <= w_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_bin   <= w_next[6:0];
                  r_err   <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign bin_out = r_bin;
   assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Directed bench for bcd_to_bin_serial: vector table, corner sequences
// (start during SHIFT/DONE, reset mid-conversion) and a full 00-99 sweep.
module tb_bcd_to_bin_serial;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] bcd_in;
   logic       busy;
   logic       done;
   logic [6:0] bin_out;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [6:0] prev_bin;

   typedef struct {
      logic [7:0] bcd;
      logic [6:0] bin;
      logic       err;
      int         lat;
   } vec_t;

   vec_t vecs[10];

   bcd_to_bin_serial dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Launch one conversion and check latency, busy length, result and hold.
   // lat = clock edges from the accepting edge to the edge that raises done.
   task automatic run_conv(input logic [7:0] v, input logic [6:0] eb,
                           input logic ee, input int lat, input string nm);
      int n;
      int nbusy;
      bit seen;
      bit stable;
      @(negedge clk);
      start  = 1'b1;
      bcd_in = v;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bcd_in = ~v;          // later bus changes must not leak into the result
      n = 0; nbusy = 0; seen = 0; stable = 1;
      while (!seen && n < 20) begin
         if (busy) nbusy++;
         if (done) seen = 1;
         else begin
            if (bin_out !== prev_bin) stable = 0;
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk({nm, " done_seen"}, 32'(seen), 32'd1);
      chk({nm, " latency"}, 32'(n), 32'(lat));
      chk({nm, " busy_len"}, 32'(nbusy), 32'(lat + 1));
      chk({nm, " bin_out"}, 32'(bin_out), 32'(eb));
      chk({nm, " err"}, 32'(err), 32'(ee));
      chk({nm, " hold"}, 32'(stable), 32'd1);
      @(posedge clk);
      #1;
      chk({nm, " post_done"}, {30'd0, busy, done}, 32'd0);
      prev_bin = eb;
   endtask

   initial begin
      int n;
      int ndone;
      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = 8'h00;
      prev_bin = 7'd0;

      vecs[0] = '{8'h99, 7'd99, 1'b0, 7};
      vecs[1] = '{8'h00, 7'd0,  1'b0, 7};
      vecs[2] = '{8'h47, 7'd47, 1'b0, 7};
      vecs[3] = '{8'h10, 7'd10, 1'b0, 7};
      vecs[4] = '{8'h3A, 7'd0,  1'b1, 0};
      vecs[5] = '{8'h58, 7'd58, 1'b0, 7};
      vecs[6] = '{8'hB2, 7'd0,  1'b1, 0};
      vecs[7] = '{8'h09, 7'd9,  1'b0, 7};
      vecs[8] = '{8'hFF, 7'd0,  1'b1, 0};
      vecs[9] = '{8'h90, 7'd90, 1'b0, 7};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {28'd0, busy, done, err, |bin_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++)
         run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat,
                  $sformatf("vec%0d", i));

      // Start pulses during SHIFT and DONE are dropped.
      @(negedge clk);
      start = 1'b1; bcd_in = 8'h25;
      @(posedge clk); #1;
      start = 1'b0; bcd_in = 8'h81;
      repeat (2) @(posedge clk);
      #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 3;
      while (!done && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("noq latency", 32'(n), 32'd7);
      chk("noq bin_out", 32'(bin_out), 32'd25);
      start = 1'b1;          // sampled on the edge leaving DONE
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) ndone++;
         @(posedge clk); #1;
      end
      chk("noq no_second_run", 32'(ndone), 32'd0);
      chk("noq bin_hold", 32'(bin_out), 32'd25);
      prev_bin = 7'd25;
      run_conv(8'h81, 7'd81, 1'b0, 7, "after_noq");

      // Reset on the 4th SHIFT cycle.
      @(negedge clk);
      start = 1'b1; bcd_in = 8'h63;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b1;
      #1;
      chk("midrst outputs", {28'd0, busy, done, err, |bin_out}, 32'd0);
      @(negedge clk); reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      chk("midrst no_done", 32'(ndone), 32'd0);
      prev_bin = 7'd0;
      run_conv(8'h12, 7'd12, 1'b0, 7, "after_rst");

      // Full sweep of legal codes against 10*tens + units.
      for (int t = 0; t < 10; t++)
         for (int u = 0; u < 10; u++)
            run_conv({4'(t), 4'(u)}, 7'(10 * t + u), 1'b0, 7,
                     $sformatf("sweep%0d%0d", t, u));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
